// File: rtl/rpn_eval_ctrl_pkg.sv
// rpn_pkg: shared types and constants for the RPN evaluator.
//   tok_kind_e : token kinds (kind 3 is reserved and decoded as END)
//   op_e       : operator codes carried in tok_data[1:0]
//   err_e      : result error codes
//   state_e    : controller states
package rpn_pkg;

    localparam int unsigned DEPTH_DEF      = 6;
    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned STK_CAP        = (1 << DEPTH_DEF) - 1;
    localparam int unsigned ERR_W          = 3;

    typedef enum logic [1:0] {
        TOK_OPERAND  = 2'd0,
        TOK_OPERATOR = 2'd1,
        TOK_END      = 2'd2
    } tok_kind_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_e;

    typedef enum logic [ERR_W-1:0] {
        ERR_OK        = 3'd0,
        ERR_UNDERFLOW = 3'd1,
        ERR_OVERFLOW  = 3'd2,
        ERR_BAD_END   = 3'd3,
        ERR_DIV_ZERO  = 3'd4
    } err_e;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_SKIP = 2'd1,
        ST_DIVW = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/rpn_eval_ctrl_if.sv
// rpn_eval_ctrl_if: token, stack-command and result buses of the evaluator.
//   tok_*  : token stream in (valid/ready)
//   stk_*  : commands to / top-of-stack from the external operand stack
//   res_*  : one result per expression out (valid/ready)
// master = evaluator side, slave = tokenizer/stack/sink side.
interface rpn_eval_ctrl_if
    import rpn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) ();

    logic                  tok_valid;
    logic                  tok_ready;
    logic [1:0]            tok_kind;
    logic [DATA_WIDTH-1:0] tok_data;

    logic                  stk_push;
    logic                  stk_pop2;
    logic                  stk_flush;
    logic [DATA_WIDTH-1:0] stk_wdata;
    logic [DATA_WIDTH-1:0] stk_top;
    logic [DATA_WIDTH-1:0] stk_next;

    logic                  res_valid;
    logic                  res_ready;
    logic [DATA_WIDTH-1:0] res_data;
    logic [ERR_W-1:0]      res_err;

    modport master (
        input  tok_valid, tok_kind, tok_data,
        output tok_ready,
        output stk_push, stk_pop2, stk_flush, stk_wdata,
        input  stk_top, stk_next,
        output res_valid, res_data, res_err,
        input  res_ready
    );

    modport slave (
        output tok_valid, tok_kind, tok_data,
        input  tok_ready,
        input  stk_push, stk_pop2, stk_flush, stk_wdata,
        output stk_top, stk_next,
        input  res_valid, res_data, res_err,
        output res_ready
    );

endinterface

// File: rtl/rpn_eval_ctrl_div_seq.sv
// rpn_div_seq: sequential signed restoring divider, quotient truncated toward zero.
//   start_i    : load operands (one-cycle pulse, ignored while busy)
//   dividend_i : a, divisor_i : b (b must be nonzero)
//   busy_o     : high from the cycle after start until the done cycle ends
//   done_o     : one-cycle pulse, W+1 cycles after start, quo_o valid with it
// Most-negative / -1 wraps to the most-negative value.
module rpn_div_seq #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] quo_o
);

    localparam int unsigned CW = $clog2(W + 1);

    logic          busy_q;
    logic          done_q;
    logic          neg_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  rem_q;
    logic [W-1:0]  quo_q;
    logic [W-1:0]  dvs_q;
    logic [W-1:0]  res_q;

    logic [W-1:0]  abs_a;
    logic [W-1:0]  abs_b;
    logic [W:0]    rem_s;
    logic [W-1:0]  diff;
    logic          ge;
    logic [W-1:0]  rem_n;
    logic [W-1:0]  quo_n;

    // Magnitudes as unsigned; the most-negative value maps to 2^(W-1).
    assign abs_a = dividend_i[W-1] ? W'(-dividend_i) : dividend_i;
    assign abs_b = divisor_i[W-1]  ? W'(-divisor_i)  : divisor_i;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_s = {rem_q, quo_q[W-1]};
        ge    = (rem_s >= {1'b0, dvs_q});
        diff  = W'(rem_s - {1'b0, dvs_q});
        rem_n = ge ? diff : rem_s[W-1:0];
        quo_n = {quo_q[W-2:0], ge};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            neg_q  <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            res_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (start_i && !busy_q) begin
                busy_q <= 1'b1;
                cnt_q  <= CW'(W);
                rem_q  <= '0;
                quo_q  <= abs_a;
                dvs_q  <= abs_b;
                neg_q  <= dividend_i[W-1] ^ divisor_i[W-1];
            end else if (busy_q) begin
                if (cnt_q != '0) begin
                    rem_q <= rem_n;
                    quo_q <= quo_n;
                    cnt_q <= cnt_q - CW'(1);
                    // Last step: apply the sign so the result is ready with done.
                    if (cnt_q == CW'(1)) begin
                        done_q <= 1'b1;
                        res_q  <= neg_q ? W'(-quo_n) : quo_n;
                    end
                end else begin
                    busy_q <= 1'b0;
                end
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign quo_o  = res_q;

endmodule

// File: rtl/rpn_eval_ctrl.sv
// rpn_eval_ctrl: postfix expression evaluator, master of the external operand stack.
//   clk, rst : clock, asynchronous active-low reset (shared with the stack)
//   bus      : rpn_eval_ctrl_if.master (token in, stack commands, result out)
// Stack commands are issued in the same cycle the token is accepted so the
// next token already sees the updated stk_top/stk_next.
// Optional: define RPN_DIV_EN for signed sequential DIV (operator 3);
// otherwise operator 3 is reported as BAD_END.
module rpn_eval_ctrl
    import rpn_pkg::*;
#(
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input logic             clk,
    input logic             rst,
    rpn_eval_ctrl_if.master bus
);

    localparam logic [DEPTH-1:0] CNT_FULL = {DEPTH{1'b1}};
    localparam logic [DEPTH-1:0] CNT_ONE  = DEPTH'(1);
    localparam logic [DEPTH-1:0] CNT_TWO  = DEPTH'(2);

    state_e                state_q, state_d;
    logic [DEPTH-1:0]      cnt_q, cnt_d;
    err_e                  err_q, err_d;
    logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic                  res_valid_q, res_valid_d;
    logic                  tok_ready_q, tok_ready_d;

    logic                  push_c, pop2_c, flush_c;
    logic [DATA_WIDTH-1:0] wdata_c;
    logic [DATA_WIDTH-1:0] alu_c;
    logic                  tok_fire;
    op_e                   tok_op;

`ifdef RPN_DIV_EN
    logic                  div_start_c;
    logic                  div_busy;
    logic                  div_done;
    logic [DATA_WIDTH-1:0] div_quo;

    rpn_div_seq #(
        .W(DATA_WIDTH)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start_c),
        .dividend_i (bus.stk_next),
        .divisor_i  (bus.stk_top),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quo_o      (div_quo)
    );
`endif

    assign tok_fire = bus.tok_valid && tok_ready_q;
    assign tok_op   = op_e'(bus.tok_data[1:0]);

    // a = stk_next, b = stk_top; results wrap to DATA_WIDTH bits.
    always_comb begin
        alu_c = '0;
        case (tok_op)
            OP_ADD:  alu_c = bus.stk_next + bus.stk_top;
            OP_SUB:  alu_c = bus.stk_next - bus.stk_top;
            OP_MUL:  alu_c = bus.stk_next * bus.stk_top;
            default: alu_c = '0;
        endcase
    end

    // Next-state, stack commands and result register updates.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        push_c      = 1'b0;
        pop2_c      = 1'b0;
        flush_c     = 1'b0;
        wdata_c     = '0;
`ifdef RPN_DIV_EN
        div_start_c = 1'b0;
`endif
        case (state_q)
            ST_RUN: begin
                if (tok_fire) begin
                    if (bus.tok_kind == TOK_OPERAND) begin
                        if (cnt_q == CNT_FULL) begin
                            err_d   = ERR_OVERFLOW;
                            state_d = ST_SKIP;
                        end else begin
                            push_c  = 1'b1;
                            wdata_c = bus.tok_data;
                            cnt_d   = cnt_q + CNT_ONE;
                        end
                    end else if (bus.tok_kind == TOK_OPERATOR) begin
                        if (cnt_q < CNT_TWO) begin
                            err_d   = ERR_UNDERFLOW;
                            state_d = ST_SKIP;
                        end else if (tok_op == OP_DIV) begin
`ifdef RPN_DIV_EN
                            if (bus.stk_top == '0) begin
                                err_d   = ERR_DIV_ZERO;
                                state_d = ST_SKIP;
                            end else if (!div_busy) begin
                                div_start_c = 1'b1;
                                state_d     = ST_DIVW;
                            end
`else
                            err_d   = ERR_BAD_END;
                            state_d = ST_SKIP;
`endif
                        end else begin
                            push_c  = 1'b1;
                            pop2_c  = 1'b1;
                            wdata_c = alu_c;
                            cnt_d   = cnt_q - CNT_ONE;
                        end
                    end else begin
                        // END and reserved kind 3 both close the expression.
                        if (cnt_q != CNT_ONE) begin
                            err_d = ERR_BAD_END;
                        end else begin
                            res_data_d = bus.stk_top;
                        end
                        res_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_SKIP: begin
                if (tok_fire && bus.tok_kind[1]) begin
                    res_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DIVW: begin
`ifdef RPN_DIV_EN
                if (div_done) begin
                    push_c  = 1'b1;
                    pop2_c  = 1'b1;
                    wdata_c = div_quo;
                    cnt_d   = cnt_q - CNT_ONE;
                    state_d = ST_RUN;
                end
`else
                state_d = ST_RUN;
`endif
            end
            ST_DONE: begin
                if (res_valid_q && bus.res_ready) begin
                    flush_c     = 1'b1;
                    cnt_d       = '0;
                    err_d       = ERR_OK;
                    res_data_d  = '0;
                    res_valid_d = 1'b0;
                    state_d     = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        tok_ready_d = (state_d == ST_RUN) || (state_d == ST_SKIP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            err_q       <= ERR_OK;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            tok_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            tok_ready_q <= tok_ready_d;
        end
    end

    assign bus.tok_ready = tok_ready_q;
    assign bus.stk_push  = push_c;
    assign bus.stk_pop2  = pop2_c;
    assign bus.stk_flush = flush_c;
    assign bus.stk_wdata = wdata_c;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_err   = err_q;

endmodule

// File: tb/tb_rpn_eval_ctrl.sv
// tb_rpn_eval_ctrl: directed bench for rpn_eval_ctrl with a behavioural stack.
// Build with +define+RPN_DIV_EN to cover the divider path.
module tb_rpn_eval_ctrl;
    import rpn_pkg::*;

    localparam int unsigned DW = 32;
    localparam logic [1:0] K_OPND = 2'd0;
    localparam logic [1:0] K_OPR  = 2'd1;
    localparam logic [1:0] K_END  = 2'd2;
    localparam logic [1:0] K_RSV  = 2'd3;
    localparam int C_NONE  = 0;
    localparam int C_PUSH  = 1;
    localparam int C_REP   = 2;
    localparam int C_FLUSH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    rpn_eval_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    rpn_eval_ctrl #(.DEPTH(6), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // External operand stack: slot 0 unused, top at mem[sp].
    logic [DW-1:0] mem [0:63];
    int sp = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp <= 0;
        end else if (bus.stk_flush) begin
            sp <= 0;
        end else if (bus.stk_push && bus.stk_pop2) begin
            mem[6'(sp - 1)] <= bus.stk_wdata;
            sp <= sp - 1;
        end else if (bus.stk_push) begin
            mem[6'(sp + 1)] <= bus.stk_wdata;
            sp <= sp + 1;
        end
    end

    always_comb begin
        bus.stk_top  = (sp >= 1) ? mem[6'(sp)] : '0;
        bus.stk_next = (sp >= 2) ? mem[6'(sp - 1)] : '0;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, got, exp);
    endtask

    function automatic int cur_cmd();
        if (bus.stk_push && bus.stk_pop2) return C_REP;
        if (bus.stk_push) return C_PUSH;
        if (bus.stk_pop2) return 3;
        if (bus.stk_flush) return C_FLUSH;
        return C_NONE;
    endfunction

    // Present one token, check the stack command issued in its accept cycle.
    task automatic put_tok(input logic [1:0] k, input logic [31:0] d, input int ec,
                           input logic [31:0] ew, input string nm);
        int n = 0;
        bus.tok_valid = 1'b1;
        bus.tok_kind  = k;
        bus.tok_data  = d;
        @(negedge clk);
        while (!bus.tok_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.tok_ready) begin
            chk({nm, " tok_ready timeout"}, 32'(bus.tok_ready), 32'd1);
        end else begin
            chk({nm, " cmd"}, 32'(cur_cmd()), 32'(ec));
            if (ec != C_NONE) chk({nm, " wdata"}, bus.stk_wdata, ew);
        end
        @(posedge clk);
        #1;
        bus.tok_valid = 1'b0;
    endtask

    // Wait for a result, check it, handshake and check the flush.
    task automatic get_res(input logic [31:0] ed, input logic [2:0] ee, input string nm);
        int n = 0;
        @(negedge clk);
        while (!bus.res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " res_valid"}, 32'(bus.res_valid), 32'd1);
        chk({nm, " res_data"}, bus.res_data, ed);
        chk({nm, " res_err"}, 32'(bus.res_err), 32'(ee));
        chk({nm, " tok_ready in DONE"}, 32'(bus.tok_ready), 32'd0);
        bus.res_ready = 1'b1;
        #1;
        chk({nm, " flush"}, 32'(cur_cmd()), 32'(C_FLUSH));
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        chk({nm, " stack empty"}, 32'(sp), 32'd0);
        chk({nm, " res_valid cleared"}, 32'(bus.res_valid), 32'd0);
    endtask

    task automatic chk_zero_outputs(input string nm);
        chk({nm, " tok_ready"}, 32'(bus.tok_ready), 32'd0);
        chk({nm, " cmd"}, 32'(cur_cmd()), 32'(C_NONE));
        chk({nm, " wdata"}, bus.stk_wdata, 32'd0);
        chk({nm, " res"}, {28'd0, bus.res_valid, bus.res_err}, 32'd0);
        chk({nm, " res_data"}, bus.res_data, 32'd0);
    endtask

`ifdef RPN_DIV_EN
    // After a DIV token: count tok_ready-low cycles and capture the replace.
    task automatic div_wait(input logic [31:0] eq, input string nm);
        int n_low = 0;
        int n_rep = 0;
        logic [31:0] w = '0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.tok_ready) break;
            n_low++;
            if (bus.stk_push && bus.stk_pop2) begin
                n_rep++;
                w = bus.stk_wdata;
            end
        end
        chk({nm, " busy cycles"}, 32'(n_low), 32'd33);
        chk({nm, " replace count"}, 32'(n_rep), 32'd1);
        chk({nm, " quotient"}, w, eq);
    endtask
`endif

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] data;
        int          cmd;
        logic [31:0] wdata;
        logic [31:0] res;
        logic [2:0]  err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [1:0] k, input logic [31:0] d, input int c,
                                input logic [31:0] w, input logic [31:0] r, input logic [2:0] e);
        vec_t v;
        v.kind = k; v.data = d; v.cmd = c; v.wdata = w; v.res = r; v.err = e;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.tok_valid = 1'b0;
        bus.tok_kind  = 2'd0;
        bus.tok_data  = '0;
        bus.res_ready = 1'b0;

        // 3 4 SUB 5 MUL END -> -5
        tbl.push_back(mk(K_OPND, 32'd3, C_PUSH, 32'd3, 0, 0));
        tbl.push_back(mk(K_OPND, 32'd4, C_PUSH, 32'd4, 0, 0));
        tbl.push_back(mk(K_OPR,  32'd1, C_REP,  32'hFFFF_FFFF, 0, 0));
        tbl.push_back(mk(K_OPND, 32'd5, C_PUSH, 32'd5, 0, 0));
        tbl.push_back(mk(K_OPR,  32'd2, C_REP,  32'hFFFF_FFFB, 0, 0));
        tbl.push_back(mk(K_END,  32'd0, C_NONE, 0, 32'hFFFF_FFFB, 3'd0));
        // 7 ADD 1 END -> UNDERFLOW, 1 discarded
        tbl.push_back(mk(K_OPND, 32'd7, C_PUSH, 32'd7, 0, 0));
        tbl.push_back(mk(K_OPR,  32'd0, C_NONE, 0, 0, 0));
        tbl.push_back(mk(K_OPND, 32'd1, C_NONE, 0, 0, 0));
        tbl.push_back(mk(K_END,  32'd0, C_NONE, 0, 32'd0, 3'd1));
        // 0x7FFFFFFF 1 ADD, reserved kind as END -> wraps to 0x80000000
        tbl.push_back(mk(K_OPND, 32'h7FFF_FFFF, C_PUSH, 32'h7FFF_FFFF, 0, 0));
        tbl.push_back(mk(K_OPND, 32'd1, C_PUSH, 32'd1, 0, 0));
        tbl.push_back(mk(K_OPR,  32'd0, C_REP,  32'h8000_0000, 0, 0));
        tbl.push_back(mk(K_RSV,  32'd0, C_NONE, 0, 32'h8000_0000, 3'd0));
        // 0x10000 * 0x10000 wraps to 0
        tbl.push_back(mk(K_OPND, 32'h0001_0000, C_PUSH, 32'h0001_0000, 0, 0));
        tbl.push_back(mk(K_OPND, 32'h0001_0000, C_PUSH, 32'h0001_0000, 0, 0));
        tbl.push_back(mk(K_OPR,  32'd2, C_REP,  32'd0, 0, 0));
        tbl.push_back(mk(K_END,  32'd0, C_NONE, 0, 32'd0, 3'd0));
        // END on empty stack -> BAD_END
        tbl.push_back(mk(K_END,  32'd0, C_NONE, 0, 32'd0, 3'd3));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("tok_ready after reset", 32'(bus.tok_ready), 32'd1);

        for (int i = 0; i < tbl.size(); i++) begin
            put_tok(tbl[i].kind, tbl[i].data, tbl[i].cmd, tbl[i].wdata, $sformatf("vec%0d", i));
            if (tbl[i].kind[1]) get_res(tbl[i].res, tbl[i].err, $sformatf("vec%0d", i));
        end

        // Fill to capacity, 64th operand overflows, then recover.
        for (int i = 1; i <= 63; i++) put_tok(K_OPND, 32'(i), C_PUSH, 32'(i), $sformatf("fill%0d", i));
        chk("stack full", 32'(sp), 32'd63);
        put_tok(K_OPND, 32'd64, C_NONE, 0, "overflow operand");
        put_tok(K_END, 32'd0, C_NONE, 0, "overflow end");
        get_res(32'd0, 3'd2, "overflow");
        put_tok(K_OPND, 32'd2, C_PUSH, 32'd2, "after ovf push");
        put_tok(K_END, 32'd0, C_NONE, 0, "after ovf end");
        get_res(32'd2, 3'd0, "after ovf");

        // BAD_END with result held while res_ready is low.
        put_tok(K_OPND, 32'd1, C_PUSH, 32'd1, "hold 1");
        put_tok(K_OPND, 32'd2, C_PUSH, 32'd2, "hold 2");
        put_tok(K_END, 32'd0, C_NONE, 0, "hold end");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("hold c%0d status", c),
                {27'd0, bus.res_valid, bus.res_err, bus.tok_ready}, {27'd0, 1'b1, 3'd3, 1'b0});
            chk($sformatf("hold c%0d data", c), bus.res_data, 32'd0);
        end
        get_res(32'd0, 3'd3, "hold");

`ifdef RPN_DIV_EN
        put_tok(K_OPND, 32'hFFFF_FFF9, C_PUSH, 32'hFFFF_FFF9, "div -7");
        put_tok(K_OPND, 32'd2, C_PUSH, 32'd2, "div 2");
        put_tok(K_OPR, 32'd3, C_NONE, 0, "div op");
        div_wait(32'hFFFF_FFFD, "div -7/2");
        put_tok(K_END, 32'd0, C_NONE, 0, "div end");
        get_res(32'hFFFF_FFFD, 3'd0, "div -7/2");

        put_tok(K_OPND, 32'd5, C_PUSH, 32'd5, "dz 5");
        put_tok(K_OPND, 32'd0, C_PUSH, 32'd0, "dz 0");
        put_tok(K_OPR, 32'd3, C_NONE, 0, "dz op");
        @(negedge clk);
        chk("dz no divide wait", 32'(bus.tok_ready), 32'd1);
        put_tok(K_END, 32'd0, C_NONE, 0, "dz end");
        get_res(32'd0, 3'd4, "div zero");

        put_tok(K_OPND, 32'h8000_0000, C_PUSH, 32'h8000_0000, "min");
        put_tok(K_OPND, 32'hFFFF_FFFF, C_PUSH, 32'hFFFF_FFFF, "neg1");
        put_tok(K_OPR, 32'd3, C_NONE, 0, "min div op");
        div_wait(32'h8000_0000, "min/-1");
        put_tok(K_END, 32'd0, C_NONE, 0, "min end");
        get_res(32'h8000_0000, 3'd0, "min/-1");

        // Reset in the middle of a divide.
        put_tok(K_OPND, 32'd6, C_PUSH, 32'd6, "rdiv 6");
        put_tok(K_OPND, 32'd3, C_PUSH, 32'd3, "rdiv 3");
        put_tok(K_OPR, 32'd3, C_NONE, 0, "rdiv op");
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk_zero_outputs("reset in div");
        @(negedge clk);
        rst = 1'b1;
        put_tok(K_OPND, 32'd9, C_PUSH, 32'd9, "rdiv 9");
        put_tok(K_END, 32'd0, C_NONE, 0, "rdiv end");
        get_res(32'd9, 3'd0, "after div reset");
`else
        put_tok(K_OPND, 32'd5, C_PUSH, 32'd5, "nodiv 5");
        put_tok(K_OPND, 32'd2, C_PUSH, 32'd2, "nodiv 2");
        put_tok(K_OPR, 32'd3, C_NONE, 0, "nodiv op");
        put_tok(K_END, 32'd0, C_NONE, 0, "nodiv end");
        get_res(32'd0, 3'd3, "div disabled");
`endif

        // Reset with five operands stacked and a token pending.
        for (int i = 1; i <= 5; i++) put_tok(K_OPND, 32'(i * 10), C_PUSH, 32'(i * 10), $sformatf("rst%0d", i));
        bus.tok_valid = 1'b1;
        bus.tok_kind  = K_OPND;
        bus.tok_data  = 32'd77;
        rst = 1'b0;
        #1;
        chk_zero_outputs("reset cnt5");
        chk("reset cnt5 stack", 32'(sp), 32'd0);
        bus.tok_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        put_tok(K_OPND, 32'd9, C_PUSH, 32'd9, "post rst 9");
        put_tok(K_END, 32'd0, C_NONE, 0, "post rst end");
        get_res(32'd9, 3'd0, "after reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rpn_eval_ctrl.md
Name: rpn_eval_ctrl

Overview:
- Postfix (RPN) expression evaluator that drives the calculator's operand stack as its master.
- Consumes a token stream (operand / operator / end) over a valid/ready handshake.
- Issues push, pop2-with-push and flush commands to the stack, and returns one result per expression over a second valid/ready handshake.
- Sits between the tokenizer and the result sink; the stack instance is external.

Parameters:
- DEPTH, 6, log2 of stack array size; usable capacity is (1<<DEPTH)-1 = 63 entries (slot 0 unused).
- DATA_WIDTH, 32, operand/result width, two's complement.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset
- tok_valid  input  1  token present
- tok_ready  output  1  token accepted when tok_valid&&tok_ready
- tok_kind  input  2  0 OPERAND, 1 OPERATOR, 2 END, 3 reserved (treated as END)
- tok_data  input  DATA_WIDTH  operand value, or operator code in [1:0]: 0 ADD, 1 SUB, 2 MUL, 3 DIV
- stk_push  output  1  stack push command
- stk_pop2  output  1  stack pop-two command; with stk_push means replace top two with stk_wdata
- stk_flush  output  1  stack clear
- stk_wdata  output  DATA_WIDTH  stack write data
- stk_top  input  DATA_WIDTH  stack top, combinational
- stk_next  input  DATA_WIDTH  stack second entry, combinational
- res_valid  output  1  result present
- res_ready  input  1  result consumed
- res_data  output  DATA_WIDTH  result value (0 when res_err != 0)
- res_err  output  3  0 OK, 1 UNDERFLOW, 2 OVERFLOW, 3 BAD_END, 4 DIV_ZERO

Behaviour:
- Reset: state RUN; cnt=0; all outputs 0; tok_ready=0 during reset, 1 from the first RUN cycle.
- cnt (DEPTH bits) mirrors stack occupancy. Stack commands are single-cycle pulses. Stack outputs are valid the cycle after a command.
- State RUN, tok_ready=1, one token per cycle:
  - OPERAND: if cnt==63, latch err=OVERFLOW and go to SKIP. Else stk_push=1, stk_wdata=tok_data, cnt+1.
  - OPERATOR: if cnt<2, err=UNDERFLOW, go to SKIP. Else a=stk_next, b=stk_top; result = a op b, low DATA_WIDTH bits (wrap, no saturation). stk_push=stk_pop2=1, stk_wdata=result, cnt-1.
  - END: if cnt!=1, err=BAD_END, go to DONE. Else latch res_data=stk_top and go to DONE.
- SKIP: tok_ready=1; tokens are discarded, no stack commands; the END token moves to DONE.
- DONE: tok_ready=0; res_valid=1 holds stable until res_ready. On handshake: stk_flush=1 for one cycle, cnt=0, clear err/res regs, return to RUN. res_ready while res_valid=0 is ignored.
- The first error latched wins; later errors are not reported.
- Reset asserted mid-expression or mid-divide aborts everything. The shared stack is reset by the same rst.

Optional Feature:
- Macro RPN_DIV_EN.
- Defined:
  - Operator 3 is DIV: signed, truncates toward zero, via a sequential divider.
  - On DIV with cnt>=2, latch a/b and go to state DIVW for DATA_WIDTH+1 cycles with tok_ready=0.
  - On completion, issue push+pop2 with the quotient and return to RUN.
  - b==0 gives err=DIV_ZERO and SKIP, with no divide started.
  - Most-negative / -1 wraps to the most-negative value.
- Undefined: operator 3 sets err=BAD_END and goes to SKIP; no DIVW state and no divider.

Decomposition:
- Package rpn_pkg holds:
  - tok_kind_e (OPERAND, OPERATOR, END)
  - op_e (ADD, SUB, MUL, DIV)
  - err_e (OK, UNDERFLOW, OVERFLOW, BAD_END, DIV_ZERO)
  - state_e (RUN, SKIP, DIVW, DONE)
  - localparam STK_CAP = (1<<DEPTH)-1
- Sub-module rpn_div_seq: start/busy/done restoring divider with sign fix-up, instantiated only under RPN_DIV_EN.

Test Plan:
- Tokens 3, 4, SUB, 5, MUL, END -> pushes 3, 4; push+pop2 wdata -1; push 5; push+pop2 wdata -5; res_data=0xFFFFFFFB, res_err=0, then a flush pulse after res_ready.
- Tokens 7, ADD, 1, END -> UNDERFLOW at ADD; 1 is discarded with no push; res_err=1, res_data=0.
- 63 operands then a 64th, then END -> 64th triggers OVERFLOW, no push; res_err=2; flush on handshake; next expression 2, END returns 2.
- Tokens 1, 2, END -> res_err=3; res_ready held low 5 cycles -> res_valid and fields stable, tok_ready=0 throughout.
- RPN_DIV_EN: -7, 2, DIV, END -> tok_ready low for 33 cycles, result 0xFFFFFFFD. Then 5, 0, DIV, END -> res_err=4.
- rst low during a DIV or with cnt=5 -> all outputs 0 immediately; after release, expression 9, END returns 9.
